// File: rtl/cache2way_controller.sv
// cache2way_controller: two-way set-associative cache controller with LRU, writeback and refill
module cache2way_controller #(
  parameter int INDEX_BIT = 10,
  parameter int BLOCK_SIZE_WORDS = 4,
  parameter int TAG_BIT = 20,
  parameter int TOTAL_TAG_SIZE_BIT = 23
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cpu_req,
  input  logic                          cpu_we,
  input  logic [31:0]                   cpu_addr,
  input  logic [31:0]                   cpu_wdata,
  output logic [31:0]                   cpu_rdata,
  output logic                          cpu_ready,
  output logic [INDEX_BIT-1:0]          ram_index,
  input  logic [TOTAL_TAG_SIZE_BIT-1:0] tag0_rdata,
  input  logic [TOTAL_TAG_SIZE_BIT-1:0] tag1_rdata,
  output logic [TOTAL_TAG_SIZE_BIT-1:0] tag0_wdata,
  output logic [TOTAL_TAG_SIZE_BIT-1:0] tag1_wdata,
  output logic                          tag0_we,
  output logic                          tag1_we,
  input  logic [32*BLOCK_SIZE_WORDS-1:0] data0_rdata,
  input  logic [32*BLOCK_SIZE_WORDS-1:0] data1_rdata,
  output logic [32*BLOCK_SIZE_WORDS-1:0] data0_wdata,
  output logic [32*BLOCK_SIZE_WORDS-1:0] data1_wdata,
  output logic                          data0_we,
  output logic                          data1_we,
  output logic                          mem_req,
  output logic                          mem_we,
  output logic [31:0]                   mem_addr,
  output logic [32*BLOCK_SIZE_WORDS-1:0] mem_wdata,
  input  logic [32*BLOCK_SIZE_WORDS-1:0] mem_rdata,
  input  logic                          mem_ready,
  output logic [31:0]                   hit_count,
  output logic [31:0]                   miss_count
);
  localparam int LW = 32*BLOCK_SIZE_WORDS;
  localparam int SW = $clog2(LW);
  localparam int V = TOTAL_TAG_SIZE_BIT-1;
  localparam int U = V-1;
  localparam int D = V-2;
  typedef enum logic [2:0] {IDLE, LOOKUP, WRITEBACK, REFILL, FILL} state_t;
  state_t state, state_n;
  logic we_r, vway, h0, h1, hit, victim, vdirty;
  logic [31:0] addr_r, wdata_r;
  logic [TAG_BIT-1:0] vtag, rtag;
  logic [INDEX_BIT-1:0] ridx;
  logic [SW-1:0] sel;
  logic [LW-1:0] line_r, hline, mline, fline;
  logic [TOTAL_TAG_SIZE_BIT-1:0] vt;
  assign rtag = addr_r[31 -: TAG_BIT];
  assign ridx = addr_r[2 +: INDEX_BIT];
  assign sel = SW'(LW-1) - SW'({addr_r[1:0], 5'd0});
  // hit detection, victim choice, line merges, and FSM next-state/outputs
  always_comb begin
    h0 = tag0_rdata[V] && tag0_rdata[TAG_BIT-1:0] == rtag;
    h1 = tag1_rdata[V] && tag1_rdata[TAG_BIT-1:0] == rtag;
    hit = h0 || h1;
    victim = tag0_rdata[V] && (!tag1_rdata[V] || (tag0_rdata[U] && !tag1_rdata[U]));
    vdirty = victim ? tag1_rdata[V] && tag1_rdata[D] : tag0_rdata[V] && tag0_rdata[D];
    hline = h0 ? data0_rdata : data1_rdata;
    mline = hline;
    if (we_r) mline[sel -: 32] = wdata_r;
    fline = line_r;
    if (we_r) fline[sel -: 32] = wdata_r;
    vt = {1'b1, 1'b1, we_r, rtag};
    state_n = state;
    cpu_ready = 1'b0;
    cpu_rdata = '0;
    ram_index = state == IDLE ? (cpu_req ? cpu_addr[2 +: INDEX_BIT] : '0) : ridx;
    tag0_we = 1'b0;
    tag1_we = 1'b0;
    tag0_wdata = '0;
    tag1_wdata = '0;
    data0_we = 1'b0;
    data1_we = 1'b0;
    data0_wdata = '0;
    data1_wdata = '0;
    mem_req = 1'b0;
    mem_we = 1'b0;
    mem_addr = '0;
    mem_wdata = '0;
    case (state)
      IDLE: state_n = cpu_req ? LOOKUP : IDLE;
      LOOKUP: begin
        if (hit) begin
          cpu_ready = 1'b1;
          cpu_rdata = hline[sel -: 32];
          tag0_we = 1'b1;
          tag1_we = 1'b1;
          tag0_wdata = h0 ? {tag0_rdata[V], 1'b1, tag0_rdata[D] | we_r, tag0_rdata[TAG_BIT-1:0]}
                          : {tag0_rdata[V], 1'b0, tag0_rdata[D:0]};
          tag1_wdata = !h0 ? {tag1_rdata[V], 1'b1, tag1_rdata[D] | we_r, tag1_rdata[TAG_BIT-1:0]}
                           : {tag1_rdata[V], 1'b0, tag1_rdata[D:0]};
          data0_we = we_r && h0;
          data1_we = we_r && !h0;
          data0_wdata = mline;
          data1_wdata = mline;
          state_n = IDLE;
        end else state_n = vdirty ? WRITEBACK : REFILL;
      end
      WRITEBACK: begin
        mem_req = 1'b1;
        mem_we = 1'b1;
        mem_addr = {vtag, ridx, 2'b00};
        mem_wdata = line_r;
        state_n = mem_ready ? REFILL : WRITEBACK;
      end
      REFILL: begin
        mem_req = 1'b1;
        mem_addr = {rtag, ridx, 2'b00};
        state_n = mem_ready ? FILL : REFILL;
      end
      FILL: begin
        cpu_ready = 1'b1;
        cpu_rdata = fline[sel -: 32];
        tag0_we = 1'b1;
        tag1_we = 1'b1;
        tag0_wdata = vway ? {tag0_rdata[V], 1'b0, tag0_rdata[D:0]} : vt;
        tag1_wdata = vway ? vt : {tag1_rdata[V], 1'b0, tag1_rdata[D:0]};
        data0_we = !vway;
        data1_we = vway;
        data0_wdata = fline;
        data1_wdata = fline;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    if (rst) begin
      cpu_ready = 1'b0;
      tag0_we = 1'b0;
      tag1_we = 1'b0;
      data0_we = 1'b0;
      data1_we = 1'b0;
    end
  end
  // state register, request latch, victim capture, refill capture and event counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      we_r <= 1'b0;
      addr_r <= '0;
      wdata_r <= '0;
      vway <= 1'b0;
      vtag <= '0;
      line_r <= '0;
      hit_count <= '0;
      miss_count <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && cpu_req) begin
        we_r <= cpu_we;
        addr_r <= cpu_addr;
        wdata_r <= cpu_wdata;
      end
      if (state == LOOKUP && hit) hit_count <= hit_count + 32'd1;
      if (state == LOOKUP && !hit) begin
        miss_count <= miss_count + 32'd1;
        vway <= victim;
        vtag <= victim ? tag1_rdata[TAG_BIT-1:0] : tag0_rdata[TAG_BIT-1:0];
        line_r <= victim ? data1_rdata : data0_rdata;
      end
      if (state == REFILL && mem_ready) line_r <= mem_rdata;
    end
  end
endmodule
